keyschedule: RTL and testbench

AES-128 key expansion stage that feeds the round-key input of addroundkey. It loads a 128-bit cipher key and emits round keys 0..10 in order, one per valid/ready transfer, as a 4x4 byte matrix in the same layout the round datapath uses. Each key is computed on the fly from the previous one, so no key table is stored.

---
 rtl/aes_pkg.sv | 68 ++++++
 rtl/sbox.sv | 11 +
 rtl/keyschedule.sv | 171 +++++++++++++++++
 tb/tb_keyschedule.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) helpers.
// Build option: KEYSCHED_SBOX_REG_EN adds the WAIT state used when the
// keyschedule registers its S-box outputs.
package aes_pkg;

  typedef logic [7:0] byte_t;
  typedef byte_t [3:0][3:0] state_t;

  localparam int    NUM_ROUNDS = 10;
  localparam byte_t RCON_INIT  = 8'h01;

`ifdef KEYSCHED_SBOX_REG_EN
  typedef enum logic [1:0] {
    KS_IDLE = 2'd0,
    KS_EMIT = 2'd1,
    KS_WAIT = 2'd2
  } ks_state_e;
`else
  typedef enum logic [1:0] {
    KS_IDLE = 2'd0,
    KS_EMIT = 2'd1
  } ks_state_e;
`endif

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) multiply, shift-and-add.
  function automatic byte_t gf_mul(input byte_t a, input byte_t b);
    byte_t r;
    byte_t p;
    r = 8'h00;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        r = r ^ p;
      end else begin
        r = r;
      end
      p = xtime(p);
    end
    return r;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
  function automatic byte_t gf_inv(input byte_t a);
    byte_t r;
    byte_t p;
    r = 8'h01;
    p = a;
    for (int k = 1; k < 8; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  // Forward AES S-box: inverse followed by the affine transform.
  function automatic byte_t sbox_calc(input byte_t a);
    byte_t b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/sbox.sv
// Combinational forward AES S-box for one byte; shared with the subbytes stage.
module sbox
  import aes_pkg::*;
(
  input  byte_t data_i,
  output byte_t data_o
);

  assign data_o = sbox_calc(data_i);

endmodule

// File: rtl/keyschedule.sv
// AES-128 on-the-fly key expansion. Emits round keys 0..10 over a
// valid/ready handshake in the round datapath's [row][col] byte layout.
// Build option: KEYSCHED_SBOX_REG_EN registers the four S-box outputs and
// inserts a WAIT cycle between keys; key values are unchanged.
module keyschedule
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = aes_pkg::NUM_ROUNDS
) (
  input  logic       clk,
  input  logic       reset,
  input  state_t     keyin,
  input  logic       start,
  input  logic       keyready,
  output state_t     roundkey,
  output logic [3:0] roundnum,
  output logic       keyvalid,
  output logic       busy
);

  ks_state_e   state_q, state_d;
  state_t      key_q, key_d;
  logic [3:0]  roundnum_q, roundnum_d;
  byte_t       rcon_q, rcon_d;
  logic        keyvalid_q, keyvalid_d;
  logic        busy_q, busy_d;

  byte_t [3:0] rot_s;
  byte_t [3:0] sub_s;
  byte_t [3:0] sub_use_s;
  state_t      next_key_s;
  logic        last_round_s;

  // One round of the AES-128 key recurrence given the substituted word.
  function automatic state_t next_round_key(input state_t k,
                                            input byte_t [3:0] t,
                                            input byte_t rcon);
    state_t nk;
    for (int r = 0; r < 4; r++) begin
      nk[r][0] = k[r][0] ^ t[r] ^ ((r == 0) ? rcon : 8'h00);
    end
    for (int c = 1; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        nk[r][c] = k[r][c] ^ nk[r][c-1];
      end
    end
    return nk;
  endfunction

  // RotWord of the last column: row 0 takes the byte from row 1, and so on.
  assign rot_s[0] = key_q[1][3];
  assign rot_s[1] = key_q[2][3];
  assign rot_s[2] = key_q[3][3];
  assign rot_s[3] = key_q[0][3];

  for (genvar g = 0; g < 4; g++) begin : g_subword
    sbox u_sbox (
      .data_i (rot_s[g]),
      .data_o (sub_s[g])
    );
  end

`ifdef KEYSCHED_SBOX_REG_EN
  byte_t [3:0] sub_q, sub_d;

  // Pipeline register that cuts the S-box path away from the key register.
  always_ff @(posedge clk) begin
    if (reset) begin
      sub_q <= '0;
    end else begin
      sub_q <= sub_d;
    end
  end

  assign sub_use_s = sub_q;
`else
  assign sub_use_s = sub_s;
`endif

  assign next_key_s   = next_round_key(key_q, sub_use_s, rcon_q);
  assign last_round_s = (roundnum_q == 4'(NUM_ROUNDS));

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= KS_IDLE;
      key_q      <= '0;
      roundnum_q <= 4'd0;
      rcon_q     <= RCON_INIT;
      keyvalid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      roundnum_q <= roundnum_d;
      rcon_q     <= rcon_d;
      keyvalid_q <= keyvalid_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state, next-key and registered-output decode.
  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    roundnum_d = roundnum_q;
    rcon_d     = rcon_q;
    keyvalid_d = keyvalid_q;
    busy_d     = busy_q;
`ifdef KEYSCHED_SBOX_REG_EN
    sub_d      = sub_q;
`endif
    case (state_q)
      KS_IDLE: begin
        if (start) begin
          key_d      = keyin;
          roundnum_d = 4'd0;
          rcon_d     = RCON_INIT;
          keyvalid_d = 1'b1;
          busy_d     = 1'b1;
          state_d    = KS_EMIT;
        end else begin
          keyvalid_d = 1'b0;
          busy_d     = 1'b0;
        end
      end
      KS_EMIT: begin
        // keyvalid is always high here, so keyready alone marks a transfer.
        if (keyready) begin
          if (last_round_s) begin
            keyvalid_d = 1'b0;
            busy_d     = 1'b0;
            state_d    = KS_IDLE;
          end else begin
`ifdef KEYSCHED_SBOX_REG_EN
            sub_d      = sub_s;
            keyvalid_d = 1'b0;
            state_d    = KS_WAIT;
`else
            key_d      = next_key_s;
            roundnum_d = roundnum_q + 4'd1;
            rcon_d     = xtime(rcon_q);
`endif
          end
        end else begin
          keyvalid_d = 1'b1;
        end
      end
`ifdef KEYSCHED_SBOX_REG_EN
      KS_WAIT: begin
        key_d      = next_key_s;
        roundnum_d = roundnum_q + 4'd1;
        rcon_d     = xtime(rcon_q);
        keyvalid_d = 1'b1;
        state_d    = KS_EMIT;
      end
`endif
      default: begin
        keyvalid_d = 1'b0;
        busy_d     = 1'b0;
        state_d    = KS_IDLE;
      end
    endcase
  end

  assign roundkey = key_q;
  assign roundnum = roundnum_q;
  assign keyvalid = keyvalid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_keyschedule.sv
// Directed self-checking bench for keyschedule (FIPS-197 and all-zero keys).
module tb_keyschedule;
  import aes_pkg::*;

`ifdef KEYSCHED_SBOX_REG_EN
  localparam int GAP = 2;
`else
  localparam int GAP = 1;
`endif

  logic       clk;
  logic       reset;
  state_t     keyin;
  logic       start;
  logic       keyready;
  state_t     roundkey;
  logic [3:0] roundnum;
  logic       keyvalid;
  logic       busy;

  int checks;
  int errors;

  state_t fips_key;
  state_t zero_key;
  state_t exp_keys [0:10];
  state_t zero_r1;
  state_t zero_r10;

  keyschedule dut (
    .clk      (clk),
    .reset    (reset),
    .keyin    (keyin),
    .start    (start),
    .keyready (keyready),
    .roundkey (roundkey),
    .roundnum (roundnum),
    .keyvalid (keyvalid),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte k[i] of a big-endian 128-bit key goes to [i%4][i/4].
  function automatic state_t to_state(input logic [127:0] v);
    state_t s;
    for (int i = 0; i < 16; i++) begin
      s[i % 4][i / 4] = v[127 - 8*i -: 8];
    end
    return s;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    keyready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge where round 0 should show.
  task automatic start_key(input state_t k);
    keyin = k;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    keyready = 1'b1;
    keyin = fips_key;
    repeat (2) @(negedge clk);
    checks++; if (roundkey !== '0) begin errors++; $display("FAIL rst_key got %h want 0", roundkey); end
    checks++; if (roundnum !== 4'd0) begin errors++; $display("FAIL rst_num got %0d want 0", roundnum); end
    checks++; if (keyvalid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", keyvalid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    reset = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (keyvalid !== 1'b0 || roundkey !== '0) begin
      errors++; $display("FAIL idle_ready got valid=%b key=%h want valid=0 key=0", keyvalid, roundkey);
    end
  endtask

  task automatic test_fips_full();
    keyready = 1'b1;
    start_key(fips_key);
    checks++; if (roundkey[1][0] !== 8'h7e) begin errors++; $display("FAIL r0_byte10 got %h want 7e", roundkey[1][0]); end
    for (int r = 0; r <= 10; r++) begin
      checks++; if (keyvalid !== 1'b1) begin errors++; $display("FAIL full_valid r%0d got %b want 1", r, keyvalid); end
      checks++; if (roundnum !== 4'(r)) begin errors++; $display("FAIL full_num got %0d want %0d", roundnum, r); end
      checks++; if (roundkey !== exp_keys[r]) begin errors++; $display("FAIL full_key r%0d got %h want %h", r, roundkey, exp_keys[r]); end
      if (r < 10) begin
        if (GAP == 2) begin
          @(negedge clk);
          checks++; if (keyvalid !== 1'b0) begin errors++; $display("FAIL gap_valid r%0d got %b want 0", r, keyvalid); end
        end
        @(negedge clk);
      end
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_r10 got %b want 1", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || keyvalid !== 1'b0) begin
      errors++; $display("FAIL busy_fall got busy=%b valid=%b want 0 0 at %0d cycles", busy, keyvalid, 2 + 10*GAP);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    keyready = 1'b1;
    start_key(fips_key);
    repeat (3*GAP) @(negedge clk);
    keyready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (roundnum !== 4'd3 || roundkey !== exp_keys[3] || keyvalid !== 1'b1) begin
        errors++; $display("FAIL bp_hold c%0d got num=%0d key=%h valid=%b want 3 %h 1", i, roundnum, roundkey, keyvalid, exp_keys[3]);
      end
    end
    keyready = 1'b1;
    repeat (GAP) @(negedge clk);
    checks++; if (roundnum !== 4'd4 || roundkey !== exp_keys[4]) begin
      errors++; $display("FAIL bp_resume got num=%0d key=%h want 4 %h", roundnum, roundkey, exp_keys[4]);
    end
  endtask

  task automatic test_ignored_start();
    do_reset();
    keyready = 1'b1;
    start_key(fips_key);
    repeat (5*GAP) @(negedge clk);
    checks++; if (roundnum !== 4'd5) begin errors++; $display("FAIL ign_num5 got %0d want 5", roundnum); end
    keyin = zero_key;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5*GAP - 1) @(negedge clk);
    checks++; if (roundnum !== 4'd10 || roundkey !== exp_keys[10]) begin
      errors++; $display("FAIL ign_r10 got num=%0d key=%h want 10 %h", roundnum, roundkey, exp_keys[10]);
    end
    // start coincides with the final transfer: one IDLE cycle before it counts
    start = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || keyvalid !== 1'b0 || roundkey !== exp_keys[10]) begin
      errors++; $display("FAIL final_start got busy=%b valid=%b key=%h want 0 0 %h", busy, keyvalid, roundkey, exp_keys[10]);
    end
    @(negedge clk);
    start = 1'b0;
    checks++; if (keyvalid !== 1'b1 || roundnum !== 4'd0 || roundkey !== zero_key) begin
      errors++; $display("FAIL restart got valid=%b num=%0d key=%h want 1 0 0", keyvalid, roundnum, roundkey);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    keyready = 1'b1;
    start_key(fips_key);
    repeat (7*GAP) @(negedge clk);
    checks++; if (roundnum !== 4'd7) begin errors++; $display("FAIL mid_num7 got %0d want 7", roundnum); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (keyvalid !== 1'b0 || busy !== 1'b0 || roundnum !== 4'd0 || roundkey !== '0) begin
      errors++; $display("FAIL mid_reset got valid=%b busy=%b num=%0d key=%h want 0 0 0 0", keyvalid, busy, roundnum, roundkey);
    end
    start_key(fips_key);
    checks++; if (roundnum !== 4'd0 || roundkey !== exp_keys[0]) begin
      errors++; $display("FAIL mid_r0 got num=%0d key=%h want 0 %h", roundnum, roundkey, exp_keys[0]);
    end
    repeat (GAP) @(negedge clk);
    checks++; if (roundnum !== 4'd1 || roundkey !== exp_keys[1]) begin
      errors++; $display("FAIL mid_r1 got num=%0d key=%h want 1 %h", roundnum, roundkey, exp_keys[1]);
    end
  endtask

  task automatic test_zero_key();
    do_reset();
    keyready = 1'b1;
    start_key(zero_key);
    repeat (GAP) @(negedge clk);
    checks++; if (roundnum !== 4'd1 || roundkey !== zero_r1) begin
      errors++; $display("FAIL zero_r1 got num=%0d key=%h want 1 %h", roundnum, roundkey, zero_r1);
    end
    repeat (9*GAP) @(negedge clk);
    checks++; if (roundnum !== 4'd10 || roundkey !== zero_r10) begin
      errors++; $display("FAIL zero_r10 got num=%0d key=%h want 10 %h", roundnum, roundkey, zero_r10);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    start    = 1'b0;
    keyready = 1'b0;
    keyin    = '0;
    fips_key = to_state(128'h2b7e151628aed2a6abf7158809cf4f3c);
    zero_key = '0;
    exp_keys[0]  = fips_key;
    exp_keys[1]  = to_state(128'ha0fafe1788542cb123a339392a6c7605);
    exp_keys[2]  = to_state(128'hf2c295f27a96b9435935807a7359f67f);
    exp_keys[3]  = to_state(128'h3d80477d4716fe3e1e237e446d7a883b);
    exp_keys[4]  = to_state(128'hef44a541a8525b7fb671253bdb0bad00);
    exp_keys[5]  = to_state(128'hd4d1c6f87c839d87caf2b8bc11f915bc);
    exp_keys[6]  = to_state(128'h6d88a37a110b3efddbf98641ca0093fd);
    exp_keys[7]  = to_state(128'h4e54f70e5f5fc9f384a64fb24ea6dc4f);
    exp_keys[8]  = to_state(128'head27321b58dbad2312bf5607f8d292f);
    exp_keys[9]  = to_state(128'hac7766f319fadc2128d12941575c006e);
    exp_keys[10] = to_state(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    zero_r1  = to_state(128'h62636363626363636263636362636363);
    zero_r10 = to_state(128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    @(negedge clk);

    test_reset();
    test_fips_full();
    test_backpressure();
    test_ignored_start();
    test_reset_mid();
    test_zero_key();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
